// File: rtl/rf_wb_arb_pkg.sv
// Shared types for the register-file writeback arbiter: request payload and
// MDU buffer occupancy states.
package rf_wb_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/rf_wb_arb_fifo2.sv
// Two-entry FIFO holding MDU results waiting for the register-file write port.
// Pointers and occupancy reset; the storage array does not.
module wb_fifo2
    import rf_wb_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push_i,
    input  wb_req_t push_data_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output wb_req_t head_o
);

    occ_e    occ_q, occ_d;
    logic    wr_ptr_q, wr_ptr_d;
    logic    rd_ptr_q, rd_ptr_d;
    wb_req_t mem_q [2];
    logic    do_push, do_pop;

    assign do_push = push_i && (occ_q != OCC_FULL);
    assign do_pop  = pop_i  && (occ_q != OCC_EMPTY);

    always_comb begin
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = ~wr_ptr_q;
        if (do_pop)  rd_ptr_d = ~rd_ptr_q;
        case (occ_q)
            OCC_EMPTY: if (do_push) occ_d = OCC_ONE;
            OCC_ONE: begin
                if (do_push && !do_pop)      occ_d = OCC_FULL;
                else if (do_pop && !do_push) occ_d = OCC_EMPTY;
            end
            OCC_FULL:  if (do_pop && !do_push) occ_d = OCC_ONE;
            default:   occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q    <= OCC_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign full_o  = (occ_q == OCC_FULL);
    assign empty_o = (occ_q == OCC_EMPTY);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rf_wb_arb.sv
// Register-file write-port arbiter: the writeback pipeline normally wins, and
// buffered MDU results win once they have lost STARVE_MAX consecutive cycles.
module rf_wb_arb
    import rf_wb_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] pipe_rd_addr_i,
    input  logic [XLEN-1:0]       pipe_rd_data_i,
    input  logic                  pipe_rd_wen_i,
    input  logic                  mdu_valid_i,
    input  logic [REG_ADDR_W-1:0] mdu_rd_addr_i,
    input  logic [XLEN-1:0]       mdu_rd_data_i,
    output logic                  mdu_ready_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [XLEN-1:0]       rd_data_o,
    output logic                  rd_wen_o,
    output logic                  stall_o,
    output logic                  mdu_pending_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic             fifo_full, fifo_empty;
    wb_req_t          fifo_head, push_data;
    logic             push, pop;
    logic             pipe_req, buf_req;
    logic             grant_buf, grant_pipe;
    logic [CNT_W-1:0] starve_q, starve_d;

    assign push_data = '{addr: mdu_rd_addr_i, data: mdu_rd_data_i};

    // Ready comes from registered occupancy only, so a same-cycle pop never frees a slot.
    assign mdu_ready_o = !fifo_full;
    assign push        = mdu_valid_i && mdu_ready_o;

    wb_fifo2 u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    assign pipe_req   = pipe_rd_wen_i && (pipe_rd_addr_i != '0);
    assign buf_req    = !fifo_empty;
    assign grant_buf  = buf_req && (!pipe_req || (starve_q == CNT_MAX));
    assign grant_pipe = pipe_req && !grant_buf;
    assign pop        = grant_buf;

    always_comb begin
        rd_addr_o = '0;
        rd_data_o = '0;
        rd_wen_o  = 1'b0;
        if (grant_pipe) begin
            rd_addr_o = pipe_rd_addr_i;
            rd_data_o = pipe_rd_data_i;
            rd_wen_o  = 1'b1;
        end else if (grant_buf) begin
            rd_addr_o = fifo_head.addr;
            rd_data_o = fifo_head.data;
            rd_wen_o  = (fifo_head.addr != '0);
        end
    end

    assign stall_o       = pipe_req && grant_buf;
    assign mdu_pending_o = buf_req;

    always_comb begin
        starve_d = starve_q;
        if (grant_buf || !buf_req)    starve_d = '0;
        else if (pipe_req)            starve_d = (starve_q == CNT_MAX) ? CNT_MAX : starve_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_q <= '0;
        else        starve_q <= starve_d;
    end

endmodule

// File: tb/tb_rf_wb_arb.sv
// Directed bench for rf_wb_arb: inputs change 1ns after the rising edge,
// outputs are checked on the falling edge.
module tb_rf_wb_arb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  pipe_rd_addr;
    logic [31:0] pipe_rd_data;
    logic        pipe_rd_wen;
    logic        mdu_valid;
    logic [4:0]  mdu_rd_addr;
    logic [31:0] mdu_rd_data;
    logic        mdu_ready;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_wen;
    logic        stall;
    logic        mdu_pending;

    int n_cmp = 0;
    int n_err = 0;

    rf_wb_arb #(.STARVE_MAX(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pipe_rd_addr_i (pipe_rd_addr),
        .pipe_rd_data_i (pipe_rd_data),
        .pipe_rd_wen_i  (pipe_rd_wen),
        .mdu_valid_i    (mdu_valid),
        .mdu_rd_addr_i  (mdu_rd_addr),
        .mdu_rd_data_i  (mdu_rd_data),
        .mdu_ready_o    (mdu_ready),
        .rd_addr_o      (rd_addr),
        .rd_data_o      (rd_data),
        .rd_wen_o       (rd_wen),
        .stall_o        (stall),
        .mdu_pending_o  (mdu_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_pipe(input logic wen, input logic [4:0] addr, input logic [31:0] data);
        pipe_rd_wen  = wen;
        pipe_rd_addr = addr;
        pipe_rd_data = data;
    endtask

    task automatic set_mdu(input logic vld, input logic [4:0] addr, input logic [31:0] data);
        mdu_valid   = vld;
        mdu_rd_addr = addr;
        mdu_rd_data = data;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_port(input string tag, input logic [4:0] a, input logic [31:0] d,
                              input logic w, input logic s);
        @(negedge clk);
        check({tag, ".addr"},  {27'd0, rd_addr}, {27'd0, a});
        check({tag, ".data"},  rd_data, d);
        check({tag, ".wen"},   {31'd0, rd_wen}, {31'd0, w});
        check({tag, ".stall"}, {31'd0, stall}, {31'd0, s});
    endtask

    initial begin
        rst_n = 1'b0;
        set_pipe(1'b0, 5'd0, 32'd0);
        set_mdu(1'b0, 5'd0, 32'd0);
        #2;
        check("rst.ready",   {31'd0, mdu_ready},   32'd1);
        check("rst.pending", {31'd0, mdu_pending}, 32'd0);
        check("rst.wen",     {31'd0, rd_wen},      32'd0);
        check("rst.addr",    {27'd0, rd_addr},     32'd0);
        check("rst.data",    rd_data,              32'd0);
        // pipe request while held in reset goes straight through
        set_pipe(1'b1, 5'd5, 32'h99);
        #1;
        check("rst.pipe_wen",   {31'd0, rd_wen}, 32'd1);
        check("rst.pipe_stall", {31'd0, stall},  32'd0);
        set_pipe(1'b0, 5'd0, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // pipe only
        set_pipe(1'b1, 5'd5, 32'h11);
        for (int i = 0; i < 3; i++) begin
            check_port($sformatf("pipe%0d", i), 5'd5, 32'h11, 1'b1, 1'b0);
            next_cycle();
        end

        // MDU only: push, one-cycle eligibility delay, then drain
        set_pipe(1'b0, 5'd0, 32'd0);
        set_mdu(1'b1, 5'd7, 32'hDEAD);
        check_port("mdu.c0", 5'd0, 32'd0, 1'b0, 1'b0);
        check("mdu.c0.pending", {31'd0, mdu_pending}, 32'd0);
        next_cycle();
        set_mdu(1'b0, 5'd0, 32'd0);
        check_port("mdu.c1", 5'd7, 32'hDEAD, 1'b1, 1'b0);
        check("mdu.c1.pending", {31'd0, mdu_pending}, 32'd1);
        next_cycle();
        check("mdu.c2.pending", {31'd0, mdu_pending}, 32'd0);
        check("mdu.c2.wen",     {31'd0, rd_wen},      32'd0);
        next_cycle();

        // starvation: 4 pipeline wins, then buffer forced through
        set_mdu(1'b1, 5'd9, 32'h1234);
        next_cycle();
        set_mdu(1'b0, 5'd0, 32'd0);
        set_pipe(1'b1, 5'd3, 32'h3333);
        for (int i = 1; i <= 6; i++) begin
            if (i == 5) check_port($sformatf("starve%0d", i), 5'd9, 32'h1234, 1'b1, 1'b1);
            else        check_port($sformatf("starve%0d", i), 5'd3, 32'h3333, 1'b1, 1'b0);
            next_cycle();
        end
        check("starve.pending", {31'd0, mdu_pending}, 32'd0);

        // full / order: A then B buffered behind a busy pipe, C refused
        set_mdu(1'b1, 5'd1, 32'hA);
        @(negedge clk);
        check("full.c0.ready", {31'd0, mdu_ready}, 32'd1);
        next_cycle();
        set_mdu(1'b1, 5'd2, 32'hB);
        @(negedge clk);
        check("full.c1.ready", {31'd0, mdu_ready}, 32'd1);
        next_cycle();
        set_mdu(1'b1, 5'd4, 32'hC);
        for (int i = 2; i <= 4; i++) begin
            check_port($sformatf("full.c%0d", i), 5'd3, 32'h3333, 1'b1, 1'b0);
            check($sformatf("full.c%0d.ready", i), {31'd0, mdu_ready}, 32'd0);
            next_cycle();
        end
        check_port("full.popA", 5'd1, 32'hA, 1'b1, 1'b1);
        check("full.popA.ready", {31'd0, mdu_ready}, 32'd0);
        next_cycle();
        set_mdu(1'b0, 5'd0, 32'd0);
        set_pipe(1'b0, 5'd0, 32'd0);
        check_port("full.popB", 5'd2, 32'hB, 1'b1, 1'b0);
        next_cycle();
        check("full.drained", {31'd0, mdu_pending}, 32'd0);
        check("full.ready",   {31'd0, mdu_ready},   32'd1);

        // x0 handling
        set_mdu(1'b1, 5'd0, 32'h55);
        next_cycle();
        set_mdu(1'b0, 5'd0, 32'd0);
        check_port("x0.pop", 5'd0, 32'h55, 1'b0, 1'b0);
        check("x0.pop.pending", {31'd0, mdu_pending}, 32'd1);
        next_cycle();
        check("x0.popped", {31'd0, mdu_pending}, 32'd0);
        set_mdu(1'b1, 5'd6, 32'h66);
        next_cycle();
        set_mdu(1'b0, 5'd0, 32'd0);
        set_pipe(1'b1, 5'd0, 32'h77);
        check_port("x0.pipe_buf", 5'd6, 32'h66, 1'b1, 1'b0);
        next_cycle();
        check_port("x0.pipe_only", 5'd0, 32'd0, 1'b0, 1'b0);
        next_cycle();

        // asynchronous reset with a full buffer
        set_pipe(1'b1, 5'd3, 32'h3333);
        set_mdu(1'b1, 5'd10, 32'hA1);
        next_cycle();
        set_mdu(1'b1, 5'd11, 32'hA2);
        next_cycle();
        set_mdu(1'b0, 5'd0, 32'd0);
        check("arst.pre.ready",   {31'd0, mdu_ready},   32'd0);
        check("arst.pre.pending", {31'd0, mdu_pending}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.ready",   {31'd0, mdu_ready},   32'd1);
        check("arst.pending", {31'd0, mdu_pending}, 32'd0);
        check("arst.wen",     {31'd0, rd_wen},      32'd1);
        check("arst.stall",   {31'd0, stall},       32'd0);
        check("arst.addr",    {27'd0, rd_addr},     32'd3);
        #3;
        rst_n = 1'b1;
        set_pipe(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            check_port($sformatf("arst.post%0d", i), 5'd0, 32'd0, 1'b0, 1'b0);
            check($sformatf("arst.post%0d.pending", i), {31'd0, mdu_pending}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_wb_arb.md
RF_WB_ARB -- requirements
Module: rf_wb_arb

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 4, meaning the maximum number of consecutive cycles a buffered MDU result may lose arbitration.
REQ-002 The block SHALL have these ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pipe_rd_addr_i  input  5  writeback-stage destination register.
- pipe_rd_data_i  input  32  writeback-stage data, after load/ALU select.
- pipe_rd_wen_i  input  1  writeback-stage write request.
- mdu_valid_i  input  1  multi-cycle unit result valid.
- mdu_rd_addr_i  input  5  MDU destination register.
- mdu_rd_data_i  input  32  MDU result.
- mdu_ready_o  output  1  arbiter can accept an MDU result.
- rd_addr_o  output  5  register-file write address.
- rd_data_o  output  32  register-file write data.
- rd_wen_o  output  1  register-file write enable.
- stall_o  output  1  pipeline writeback denied this cycle; upstream holds WB inputs.
- mdu_pending_o  output  1  at least one MDU result is buffered.

Function
REQ-003 The block SHALL contain a 2-entry FIFO of {addr[4:0], data[31:0]} for MDU results, with occupancy 0/1/2 (states EMPTY, ONE, FULL).
REQ-004 mdu_ready_o SHALL equal (occupancy < 2); it SHALL NOT depend on a same-cycle pop.
REQ-005 An MDU push SHALL occur on a rising edge where mdu_valid_i and mdu_ready_o are both 1; a pushed entry SHALL become eligible for the write port no earlier than the next cycle.
REQ-006 A pipeline request SHALL be (pipe_rd_wen_i and pipe_rd_addr_i != 0); a buffer request SHALL be (occupancy != 0).
REQ-007 Grant: no requests -> rd_wen_o=0; pipeline request only -> pipeline; buffer request only -> buffer head; both -> pipeline, unless starve_cnt == STARVE_MAX, in which case buffer head.
REQ-008 When the pipeline is granted, rd_addr_o/rd_data_o SHALL equal the pipe inputs and rd_wen_o=1, combinationally in the same cycle.
REQ-009 When the buffer is granted, the head SHALL drive rd_addr_o/rd_data_o, and the head SHALL pop at the clock edge; rd_wen_o SHALL be 1 unless the head address is 0, in which case the entry pops with rd_wen_o=0.
REQ-010 stall_o SHALL be 1 exactly when a pipeline request exists and the buffer is granted.
REQ-011 A pipe_rd_wen_i with address 0 SHALL NOT request the port, SHALL NOT stall, and SHALL NOT write.
REQ-012 starve_cnt, of width $clog2(STARVE_MAX+1), SHALL increment when both request and the pipeline wins; it SHALL clear on any buffer grant or when the buffer is empty, and SHALL saturate at STARVE_MAX.
REQ-013 A simultaneous push and pop SHALL leave the occupancy unchanged and preserve FIFO order.
REQ-014 The idle default for rd_addr_o and rd_data_o SHALL be 0.
REQ-015 mdu_pending_o SHALL be (occupancy != 0).

Reset
REQ-016 Asserting rst_n=0 SHALL, asynchronously and at any time including mid-operation, set occupancy=0, starve_cnt=0, and clear the FIFO pointers; buffered results SHALL be discarded.
REQ-017 In reset, the outputs SHALL be: mdu_ready_o=1 and mdu_pending_o=0; rd_wen_o and stall_o SHALL follow pipe inputs per REQ-007 with an empty buffer, i.e. stall_o=0.
REQ-018 The FIFO data array SHALL need no reset.

Structure
REQ-019 A shared package SHALL hold REG_ADDR_W=5, XLEN=32, the wb_req_t struct {addr, data}, and the occupancy state enum.
REQ-020 The FIFO SHALL be one sub-module, wb_fifo2 (depth 2, push/pop/full/empty/head); the arbitration and starvation logic SHALL live in rf_wb_arb.

Verification
REQ-021 Pipe-only: pipe (x5, 0x11) for 3 cycles with no MDU -> rd_addr_o=5, rd_data_o=0x11, rd_wen_o=1, stall_o=0 each cycle.
REQ-022 MDU-only: push (x7, 0xDEAD) at cycle 0 -> cycle 1 rd_addr_o=7, rd_data_o=0xDEAD, rd_wen_o=1, then mdu_pending_o=0.
REQ-023 Starvation: push (x9, 0x1234), then continuous pipe writes to x3 -> pipeline granted for 4 cycles, 5th cycle buffer granted with stall_o=1, 6th cycle pipeline resumes with stall_o=0.
REQ-024 Full/order: push A (x1) and B (x2) while the pipe is busy -> mdu_ready_o=0 after 2 pushes; pops occur in order A then B; a third push in a pop cycle is refused.
REQ-025 x0: MDU result to x0 pops with rd_wen_o=0; pipe write to x0 concurrent with a buffered entry -> buffer granted, stall_o=0.
REQ-026 Reset mid-operation: FULL buffer, assert rst_n=0 asynchronously -> mdu_pending_o=0 and mdu_ready_o=1 immediately; no buffered write after release.
